// File: rtl/qupls_ptw_walk_sched.sv
// qupls_ptw_walk_sched
//   Schedules page-table walk fetches from a miss queue onto a single memory
//   read port and tracks them in a small translation-buffer of tagged slots.
//   A round-robin arbiter picks one ready miss-queue entry, the lowest free
//   slot is used as the read tag, and completed slots are retired one per
//   cycle (lowest slot first) on the sel_tran/tran_* outputs.
//
//   Ports
//     clk, rst             clock, synchronous active-high reset
//     flush                abort all walks in flight
//     req_v, req_adr       per-entry ready flags and table addresses
//     grant_v, grant_qe    one-cycle grant pulse and granted entry index
//     mem_req/adr/tag/ack  read request handshake
//     mem_resp_*           read response (tag + 64-bit data)
//     sel_tran, tran_*     completed translation; sel_tran[5]=1 means none
//     busy, tag_err        any walk outstanding; sticky stray-response flag
//
//   Optional feature: define QUPLS_PTW_SCHED_TIMEOUT_EN to give each pending
//   slot an 8-bit age counter that retires it as a fault when it saturates.

module qupls_ptw_walk_sched #(
  parameter int NQ  = 8,
  parameter int NTB = 16,
  parameter int AW  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic [NQ-1:0]          req_v,
  input  logic [NQ*AW-1:0]       req_adr,
  output logic                   grant_v,
  output logic [$clog2(NQ)-1:0]  grant_qe,
  output logic                   mem_req,
  output logic [AW-1:0]          mem_adr,
  output logic [$clog2(NTB)-1:0] mem_tag,
  input  logic                   mem_ack,
  input  logic                   mem_resp_v,
  input  logic [$clog2(NTB)-1:0] mem_resp_tag,
  input  logic [63:0]            mem_resp_data,
  output logic [5:0]             sel_tran,
  output logic [$clog2(NQ)-1:0]  tran_stk,
  output logic [63:0]            tran_pte,
  output logic                   tran_fault,
  output logic                   busy,
  output logic                   tag_err
);

  localparam int QW = $clog2(NQ);
  localparam int TW = $clog2(NTB);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t          state;
  logic [QW-1:0]   rr_ptr;
  logic [NQ-1:0]   owned;
  logic [NTB-1:0]  pend;
  logic [NTB-1:0]  done;
  logic [NTB-1:0]  fault;
  logic [NTB-1:0]  tmo;
  logic [QW-1:0]   slot_stk  [NTB];
  logic [63:0]     slot_data [NTB];

  logic [NQ-1:0]   eligible;
  logic [QW-1:0]   cand;
  logic            gnt_found;
  logic [QW-1:0]   gnt_idx;
  logic            free_found;
  logic [TW-1:0]   free_idx;
  logic            done_found;
  logic [TW-1:0]   done_idx;
  logic            resp_hit;
  logic            ack_take;

  // Round-robin search starting one past the last grant, plus lowest-free
  // and lowest-done slot pickers. Slots are judged on registered state, so a
  // slot retired this cycle is only allocatable from the next cycle.
  always_comb begin
    eligible   = req_v & ~owned;
    cand       = '0;
    gnt_found  = 1'b0;
    gnt_idx    = '0;
    for (int unsigned i = 0; i < NQ; i++) begin
      cand = rr_ptr + QW'(i + 1);
      if (!gnt_found && eligible[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
    free_found = 1'b0;
    free_idx   = '0;
    done_found = 1'b0;
    done_idx   = '0;
    for (int unsigned i = 0; i < NTB; i++) begin
      if (!free_found && !pend[i] && !done[i]) begin
        free_found = 1'b1;
        free_idx   = TW'(i);
      end
      if (!done_found && done[i]) begin
        done_found = 1'b1;
        done_idx   = TW'(i);
      end
    end
  end

  assign resp_hit = mem_resp_v && pend[mem_resp_tag];
  assign ack_take = (state == ISSUE) && mem_ack;
  assign busy     = (|pend) || (|done) || (state == ISSUE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= QW'(NQ - 1);
      owned    <= '0;
      pend     <= '0;
      done     <= '0;
      grant_v  <= 1'b0;
      grant_qe <= '0;
      mem_req  <= 1'b0;
      mem_adr  <= '0;
      mem_tag  <= '0;
      sel_tran <= 6'h3f;
      tran_stk <= '0;
      tran_pte <= '0;
      tag_err  <= 1'b0;
    end else begin
      grant_v <= 1'b0;
      if (mem_resp_v && !pend[mem_resp_tag])
        tag_err <= 1'b1;
      if (flush) begin
        state    <= IDLE;
        mem_req  <= 1'b0;
        owned    <= '0;
        pend     <= '0;
        done     <= '0;
        sel_tran <= 6'h3f;
      end else begin
        sel_tran <= 6'h3f;
        if (done_found) begin
          sel_tran               <= {1'b0, 5'(done_idx)};
          tran_stk               <= slot_stk[done_idx];
          tran_pte               <= fault[done_idx] ? '0 : slot_data[done_idx];
          done[done_idx]         <= 1'b0;
          owned[slot_stk[done_idx]] <= 1'b0;
        end
        for (int unsigned i = 0; i < NTB; i++) begin
          if (tmo[i]) begin
            pend[i] <= 1'b0;
            done[i] <= 1'b1;
          end
        end
        if (resp_hit) begin
          pend[mem_resp_tag] <= 1'b0;
          done[mem_resp_tag] <= 1'b1;
        end
        case (state)
          IDLE: begin
            if (gnt_found && free_found) begin
              grant_v  <= 1'b1;
              grant_qe <= gnt_idx;
              rr_ptr   <= gnt_idx;
              mem_req  <= 1'b1;
              mem_adr  <= req_adr[int'(gnt_idx)*AW +: AW];
              mem_tag  <= free_idx;
              state    <= ISSUE;
            end
          end
          ISSUE: begin
            if (mem_ack) begin
              pend[mem_tag]   <= 1'b1;
              owned[grant_qe] <= 1'b1;
              mem_req         <= 1'b0;
              state           <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Slot payload storage; only meaningful while the slot's control bits say
  // so, hence no reset.
  always_ff @(posedge clk) begin
    if (ack_take)
      slot_stk[mem_tag] <= grant_qe;
    if (resp_hit)
      slot_data[mem_resp_tag] <= mem_resp_data;
  end

`ifdef QUPLS_PTW_SCHED_TIMEOUT_EN
  logic [7:0] age [NTB];

  // A response arriving on the saturation cycle wins over the timeout.
  always_comb begin
    for (int unsigned i = 0; i < NTB; i++)
      tmo[i] = pend[i] && (age[i] == 8'hff) &&
               !(resp_hit && (mem_resp_tag == TW'(i)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fault      <= '0;
      tran_fault <= 1'b0;
      for (int unsigned i = 0; i < NTB; i++)
        age[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NTB; i++) begin
        if (!pend[i])
          age[i] <= '0;
        else if (age[i] != 8'hff)
          age[i] <= age[i] + 8'd1;
      end
      if (flush) begin
        fault <= '0;
      end else begin
        for (int unsigned i = 0; i < NTB; i++)
          if (tmo[i])
            fault[i] <= 1'b1;
        if (resp_hit)
          fault[mem_resp_tag] <= 1'b0;
        if (ack_take)
          fault[mem_tag] <= 1'b0;
        if (done_found)
          tran_fault <= fault[done_idx];
      end
    end
  end
`else
  assign tmo        = '0;
  assign fault      = '0;
  assign tran_fault = 1'b0;
`endif

endmodule

// File: tb/tb_qupls_ptw_walk_sched.sv
module tb_qupls_ptw_walk_sched;
  localparam int NQ  = 16;
  localparam int NTB = 16;
  localparam int AW  = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              flush = 1'b0;
  logic [NQ-1:0]     req_v = '0;
  logic [NQ*AW-1:0]  req_adr = '0;
  logic              grant_v;
  logic [3:0]        grant_qe;
  logic              mem_req;
  logic [AW-1:0]     mem_adr;
  logic [3:0]        mem_tag;
  logic              mem_ack = 1'b0;
  logic              mem_resp_v = 1'b0;
  logic [3:0]        mem_resp_tag = '0;
  logic [63:0]       mem_resp_data = '0;
  logic [5:0]        sel_tran;
  logic [3:0]        tran_stk;
  logic [63:0]       tran_pte;
  logic              tran_fault;
  logic              busy;
  logic              tag_err;

  int nvec = 0;
  int nerr = 0;

  qupls_ptw_walk_sched #(.NQ(NQ), .NTB(NTB), .AW(AW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_v(req_v), .req_adr(req_adr),
    .grant_v(grant_v), .grant_qe(grant_qe),
    .mem_req(mem_req), .mem_adr(mem_adr), .mem_tag(mem_tag), .mem_ack(mem_ack),
    .mem_resp_v(mem_resp_v), .mem_resp_tag(mem_resp_tag), .mem_resp_data(mem_resp_data),
    .sel_tran(sel_tran), .tran_stk(tran_stk), .tran_pte(tran_pte), .tran_fault(tran_fault),
    .busy(busy), .tag_err(tag_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          qe;
    logic [31:0] adr;
    logic [63:0] data;
    int          ack_dly;
    logic [3:0]  exp_tag;
  } vec_t;

  vec_t tbl [4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wait_grant(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (grant_v) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  logic ok;
  int   ng;
  int   eq [10];
  int   et [10];

  initial begin
    tbl[0] = '{qe: 0,  adr: 32'h0000_1000, data: 64'h0000_0000_0000_ABCD, ack_dly: 1, exp_tag: 4'd0};
    tbl[1] = '{qe: 5,  adr: 32'hDEAD_BEE0, data: 64'h0123_4567_89AB_CDEF, ack_dly: 0, exp_tag: 4'd0};
    tbl[2] = '{qe: 15, adr: 32'hFFFF_FFF8, data: 64'hFFFF_FFFF_FFFF_FFFF, ack_dly: 3, exp_tag: 4'd0};
    tbl[3] = '{qe: 7,  adr: 32'h0000_0000, data: 64'h8000_0000_0000_0001, ack_dly: 2, exp_tag: 4'd0};

    repeat (3) tick();
    rst = 1'b0;
    chk("rst_sel_tran", sel_tran, 6'h3f);
    chk("rst_grant_v", grant_v, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_adr", mem_adr, 0);
    chk("rst_mem_tag", mem_tag, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tag_err", tag_err, 0);
    chk("rst_tran_pte", tran_pte, 0);

    // Single-walk transactions
    for (int v = 0; v < 4; v++) begin
      req_adr[tbl[v].qe*AW +: AW] = tbl[v].adr;
      req_v = '0;
      req_v[tbl[v].qe] = 1'b1;
      wait_grant(ok);
      chk("grant_seen", ok, 1);
      req_v = '0;
      chk("grant_qe", grant_qe, tbl[v].qe);
      chk("mem_req", mem_req, 1);
      chk("mem_adr", mem_adr, tbl[v].adr);
      chk("mem_tag", mem_tag, tbl[v].exp_tag);
      for (int d = 0; d < tbl[v].ack_dly; d++) begin
        tick();
        chk("mem_req_hold", mem_req, 1);
        chk("mem_adr_hold", mem_adr, tbl[v].adr);
        chk("grant_pulse", grant_v, 0);
      end
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      chk("mem_req_drop", mem_req, 0);
      chk("busy_pend", busy, 1);
      mem_resp_v = 1'b1;
      mem_resp_tag = tbl[v].exp_tag;
      mem_resp_data = tbl[v].data;
      tick();
      mem_resp_v = 1'b0;
      chk("sel_latency", sel_tran, 6'h3f);
      tick();
      chk("sel_tran", sel_tran, {2'b00, tbl[v].exp_tag});
      chk("tran_stk", tran_stk, tbl[v].qe);
      chk("tran_pte", tran_pte, tbl[v].data);
      tick();
      chk("sel_once", sel_tran, 6'h3f);
      chk("busy_idle", busy, 0);
    end

    // Round-robin with all of 0..7 ready and immediate acks
    for (int i = 0; i < NQ; i++) req_adr[i*AW +: AW] = 32'(i * 256);
    req_v = 16'h00FF;
    mem_ack = 1'b1;
    ng = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (grant_v) begin
        chk("rr_order", grant_qe, ng);
        chk("rr_tag", mem_tag, ng);
        chk("rr_adr", mem_adr, 32'(ng * 256));
        ng++;
      end
    end
    chk("rr_count", ng, 8);
    mem_ack = 1'b0;
    req_v = '0;

    // Out-of-order responses: tag 1 then tag 0
    mem_resp_v = 1'b1; mem_resp_tag = 4'd1; mem_resp_data = 64'h11;
    tick();
    mem_resp_tag = 4'd0; mem_resp_data = 64'h10;
    chk("ooo_none_yet", sel_tran, 6'h3f);
    tick();
    mem_resp_v = 1'b0;
    chk("ooo_sel1", sel_tran, 6'h01);
    chk("ooo_stk1", tran_stk, 1);
    chk("ooo_pte1", tran_pte, 64'h11);
    tick();
    chk("ooo_sel0", sel_tran, 6'h00);
    chk("ooo_stk0", tran_stk, 0);
    chk("ooo_pte0", tran_pte, 64'h10);
    tick();
    chk("ooo_idle", sel_tran, 6'h3f);

    // Fill every slot: entries 8..15,0,1 land on slots 0,1,8..15
    for (int k = 0; k < 8; k++) eq[k] = 8 + k;
    eq[8] = 0; eq[9] = 1;
    et[0] = 0; et[1] = 1;
    for (int k = 2; k < 10; k++) et[k] = k + 6;
    req_v = 16'hFF03;
    mem_ack = 1'b1;
    ng = 0;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (grant_v) begin
        if (ng < 10) begin
          chk("fill_qe", grant_qe, eq[ng]);
          chk("fill_tag", mem_tag, et[ng]);
        end
        ng++;
      end
    end
    chk("fill_count", ng, 10);
    mem_ack = 1'b0;
    req_v = '1;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("full_nogrant", grant_v, 0);
    end
    chk("full_busy", busy, 1);

    // Retire slot 9 (entry 11); regrant only on the following cycle
    mem_resp_v = 1'b1; mem_resp_tag = 4'd9; mem_resp_data = 64'h9999_0000_1234_5678;
    tick();
    mem_resp_v = 1'b0;
    chk("free_lat", sel_tran, 6'h3f);
    tick();
    chk("free_sel", sel_tran, 6'h09);
    chk("free_stk", tran_stk, 11);
    chk("free_pte", tran_pte, 64'h9999_0000_1234_5678);
    chk("free_no_same_cycle", grant_v, 0);
    tick();
    chk("regrant_v", grant_v, 1);
    chk("regrant_qe", grant_qe, 11);
    chk("regrant_tag", mem_tag, 9);
    chk("regrant_adr", mem_adr, 32'(11 * 256));

    // Flush while in ISSUE
    flush = 1'b1;
    req_v = '0;
    tick();
    flush = 1'b0;
    chk("flush_mem_req", mem_req, 0);
    chk("flush_busy", busy, 0);
    chk("flush_sel", sel_tran, 6'h3f);
    tick();
    chk("flush_nogrant", grant_v, 0);

    // Stray response after flush
    chk("tag_err_clear", tag_err, 0);
    mem_resp_v = 1'b1; mem_resp_tag = 4'd5; mem_resp_data = 64'h5555;
    tick();
    mem_resp_v = 1'b0;
    chk("stray_tag_err", tag_err, 1);
    tick();
    chk("stray_sel", sel_tran, 6'h3f);
    chk("stray_sticky", tag_err, 1);

`ifdef QUPLS_PTW_SCHED_TIMEOUT_EN
    req_adr[3*AW +: AW] = 32'h3000;
    req_v = 16'h0008;
    wait_grant(ok);
    chk("tmo_grant", ok, 1);
    req_v = '0;
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 400; c++) begin
      tick();
      if (sel_tran != 6'h3f) begin
        ok = 1'b1;
        break;
      end
    end
    chk("tmo_seen", ok, 1);
    chk("tmo_sel", sel_tran, 6'h00);
    chk("tmo_fault", tran_fault, 1);
    chk("tmo_pte", tran_pte, 0);
    chk("tmo_stk", tran_stk, 3);
`else
    chk("fault_const", tran_fault, 0);
`endif

    // Reset while a request is outstanding
    req_adr[4*AW +: AW] = 32'h4000;
    req_v = 16'h0010;
    wait_grant(ok);
    chk("rst_mid_grant", ok, 1);
    req_v = '0;
    chk("rst_mid_req_on", mem_req, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_req_off", mem_req, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_tag_err", tag_err, 0);
    chk("rst_mid_sel", sel_tran, 6'h3f);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
